tdm_serial_port: RTL and testbench

Parametrised TDM audio serial port for the AK4619-class codec path. It generates MCLK/BICK/LRCK from the system clock and shifts N_CH DAC samples out on the codec SDIN line. It captures N_CH ADC samples from SDOUT and exchanges whole frames with the fabric over a valid/ready (DAC) and valid-strobe (ADC) interface. It generalises the fixed 4-channel/16-bit codec link to arbitrary channel count, sample width, slot width and clock ratio, and adds underrun handling.

---
 rtl/tdm_serial_port.sv | 246 ++++++++++++++++++++++++
 tb/tb_tdm_serial_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_serial_port.sv
// tdm_serial_port: TDM audio serial port for an AK4619-class codec.
// Generates MCLK/BICK/LRCK from clk, serialises one N_CH x W DAC frame per
// TDM frame on sdin and deserialises one ADC frame from sdout.
// Data uses a 1-bit delay after the frame sync edge, MSB first, one slot per
// channel with zero padding after the W data bits.
// Optional build macro: TDM_SERIAL_PORT_LOOPBACK_EN adds a 'loopback' input
// that routes the internal sdin into the capture path instead of sdout.
module tdm_serial_port #(
    parameter int W         = 16,
    parameter int N_CH      = 4,
    parameter int SLOT_BITS = 32,
    parameter int BICK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef TDM_SERIAL_PORT_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic                mclk,
    output logic                bick,
    output logic                lrck,
    output logic                sdin,
    input  logic                sdout,
    input  logic [N_CH*W-1:0]   dac_data,
    input  logic                dac_valid,
    output logic                dac_ready,
    output logic [N_CH*W-1:0]   adc_data,
    output logic                adc_valid,
    output logic                underrun
);

    localparam int FRAME  = N_CH * SLOT_BITS;
    localparam int FW     = N_CH * W;
    localparam int DIV_W  = (BICK_DIV > 1) ? $clog2(BICK_DIV) : 1;
    localparam int BIT_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int SLOT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int POS_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int IDX_W  = (FW > 1) ? $clog2(FW) : 1;

    localparam logic [DIV_W-1:0]  DIV_RISE      = DIV_W'(BICK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(BICK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(FRAME - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(N_CH - 1);
    localparam logic [POS_W-1:0]  POS_LAST      = POS_W'(SLOT_BITS - 1);
    localparam logic [POS_W-1:0]  POS_LAST_DATA = POS_W'(W - 1);

    // Clock generation state
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_bick;

    // Frame position: r_slot/r_pos decompose r_bit_cnt (bit_cnt = slot*SLOT_BITS + pos).
    // Because of the 1-bit delay, the serial bit carried while bit_cnt = b is the
    // frame position b-1; r_rx_slot/r_rx_pos hold that decomposition for capture.
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic [POS_W-1:0]  r_pos;
    logic [SLOT_W-1:0] r_rx_slot;
    logic [POS_W-1:0]  r_rx_pos;
    logic              r_rx_armed;
    logic              r_lrck;
    logic              r_sdin;

    // DAC path
    logic [FW-1:0]     r_hold;
    logic              r_hold_full;
    logic [FW-1:0]     r_play;
    logic              r_underrun;

    // ADC path
    logic [FW-1:0]     r_cap;
    logic              r_cap_done;
    logic [FW-1:0]     r_adc_data;
    logic              r_adc_valid;

    // Combinational helpers
    logic              w_rise;
    logic              w_fall;
    logic              w_load;
    logic              w_xfer;
    logic [BIT_W-1:0]  w_next_bit;
    logic [SLOT_W-1:0] w_next_slot;
    logic [POS_W-1:0]  w_next_pos;
    logic [IDX_W-1:0]  w_tx_idx;
    logic              w_tx_bit;
    logic [IDX_W-1:0]  w_rx_idx;
    logic              w_rx_in_data;
    logic              w_rx_last;
    logic              w_rx_bit;

    // BICK phase events: rising edge registered at div_cnt = BICK_DIV/2-1,
    // falling edge (and all frame-position updates) at div_cnt = BICK_DIV-1.
    assign w_rise = (r_div_cnt == DIV_RISE);
    assign w_fall = (r_div_cnt == DIV_LAST);

    // The frame load point is the falling edge on which bit_cnt wraps to 0.
    assign w_load = w_fall && (r_bit_cnt == BIT_LAST);

    // DAC handshake: a frame transfers on any rising clk edge where dac_valid
    // and dac_ready are both high; dac_ready is high exactly when the holding
    // register is empty, and it does not depend on dac_valid.
    assign w_xfer = dac_valid && !r_hold_full;

`ifdef TDM_SERIAL_PORT_LOOPBACK_EN
    assign w_rx_bit = loopback ? r_sdin : sdout;
`else
    assign w_rx_bit = sdout;
`endif

    // Next frame position after a BICK falling edge
    always_comb begin
        w_next_bit  = r_bit_cnt + 1'b1;
        w_next_pos  = r_pos + 1'b1;
        w_next_slot = r_slot;
        if (r_bit_cnt == BIT_LAST) begin
            w_next_bit = '0;
        end
        if (r_pos == POS_LAST) begin
            w_next_pos  = '0;
            w_next_slot = (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
        end
    end

    // Select the DAC bit for the current frame position (driven at the next falling edge)
    always_comb begin
        w_tx_idx = '0;
        w_tx_bit = 1'b0;
        if (r_pos <= POS_LAST_DATA) begin
            w_tx_idx = IDX_W'(r_slot) * IDX_W'(W) + (IDX_W'(W - 1) - IDX_W'(r_pos));
            w_tx_bit = r_play[w_tx_idx];
        end
    end

    // Locate the ADC bit being sampled at the current rising edge
    always_comb begin
        w_rx_idx     = '0;
        w_rx_in_data = (r_rx_pos <= POS_LAST_DATA);
        w_rx_last    = (r_rx_slot == SLOT_LAST) && (r_rx_pos == POS_LAST_DATA);
        if (w_rx_in_data) begin
            w_rx_idx = IDX_W'(r_rx_slot) * IDX_W'(W) + (IDX_W'(W - 1) - IDX_W'(r_rx_pos));
        end
    end

    // Clock divider and BICK waveform
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bick    <= 1'b0;
        end else begin
            r_div_cnt <= w_fall ? '0 : r_div_cnt + 1'b1;
            if (w_rise) begin
                r_bick <= 1'b1;
            end else if (w_fall) begin
                r_bick <= 1'b0;
            end
        end
    end

    // Frame counter, LRCK pulse and SDIN shifting on the BICK falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_slot     <= '0;
            r_pos      <= '0;
            r_rx_slot  <= SLOT_LAST;
            r_rx_pos   <= POS_LAST;
            r_rx_armed <= 1'b0;
            r_lrck     <= 1'b1;
            r_sdin     <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt  <= w_next_bit;
            r_slot     <= w_next_slot;
            r_pos      <= w_next_pos;
            r_rx_slot  <= r_slot;
            r_rx_pos   <= r_pos;
            // Capture only starts once a full BICK of the new frame has elapsed
            r_rx_armed <= 1'b1;
            r_lrck     <= (w_next_slot == '0);
            // At the load point r_play still holds the outgoing frame, so the
            // delayed last bit of the previous frame comes out correctly.
            r_sdin     <= w_tx_bit;
        end
    end

    // DAC holding register, play register and sticky underrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_play      <= '0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_load) begin
                if (r_hold_full) begin
                    r_play <= r_hold;
                end else begin
                    // Nothing new: r_play keeps the last frame, which repeats
                    r_underrun <= 1'b1;
                end
                r_hold_full <= 1'b0;
            end
            // A transfer only happens with the holding register empty, so it
            // can never overwrite a frame the load point has not taken yet.
            if (w_xfer) begin
                r_hold      <= dac_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // ADC sample capture on the BICK rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap      <= '0;
            r_cap_done <= 1'b0;
        end else begin
            r_cap_done <= 1'b0;
            if (w_rise && r_rx_armed && w_rx_in_data) begin
                r_cap[w_rx_idx] <= w_rx_bit;
                r_cap_done      <= w_rx_last;
            end
        end
    end

    // Publish the completed ADC frame with a one-cycle strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adc_data  <= '0;
            r_adc_valid <= 1'b0;
        end else begin
            r_adc_valid <= r_cap_done;
            if (r_cap_done) begin
                r_adc_data <= r_cap;
            end
        end
    end

    assign mclk      = clk;
    assign bick      = r_bick;
    assign lrck      = r_lrck;
    assign sdin      = r_sdin;
    assign dac_ready = !r_hold_full;
    assign adc_data  = r_adc_data;
    assign adc_valid = r_adc_valid;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_tdm_serial_port.sv
// tb_tdm_serial_port: directed + randomized bench for tdm_serial_port.
// The reference model derives every output from the number of clk edges
// since reset using closed-form arithmetic, plus queues of played DAC frames
// and generated ADC frames.
module tb_tdm_serial_port;

    localparam int W         = 16;
    localparam int N_CH      = 4;
    localparam int SLOT_BITS = 32;
    localparam int BICK_DIV  = 4;
    localparam int FRAME     = N_CH * SLOT_BITS;
    localparam int FW        = N_CH * W;
    localparam int H         = BICK_DIV / 2;
    localparam int LASTPOS   = (N_CH - 1) * SLOT_BITS + W - 1;
    localparam int PERIOD    = FRAME * BICK_DIV;
    localparam int FIRST_N   = (LASTPOS + 1) * BICK_DIV + (H - 1) + 2;

    logic          clk;
    logic          rst;
    logic          mclk;
    logic          bick;
    logic          lrck;
    logic          sdin;
    logic          sdout;
    logic [FW-1:0] dac_data;
    logic          dac_valid;
    logic          dac_ready;
    logic [FW-1:0] adc_data;
    logic          adc_valid;
    logic          underrun;
`ifdef TDM_SERIAL_PORT_LOOPBACK_EN
    logic          loopback;
`endif

    tdm_serial_port #(
        .W         (W),
        .N_CH      (N_CH),
        .SLOT_BITS (SLOT_BITS),
        .BICK_DIV  (BICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TDM_SERIAL_PORT_LOOPBACK_EN
        .loopback  (loopback),
`endif
        .mclk      (mclk),
        .bick      (bick),
        .lrck      (lrck),
        .sdin      (sdin),
        .sdout     (sdout),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .dac_ready (dac_ready),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .underrun  (underrun)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int            n;
    logic [FW-1:0] played_q[$];
    logic [FW-1:0] adc_q[$];
    logic [FW-1:0] hold;
    bit            hold_full;
    bit            m_underrun;
    bit            m_adc_valid;
    logic [FW-1:0] m_adc_data;
    int            last_obs;
    bit            first_seen;
    bit            feed_en;

    int            n_assert;
    int            n_fail;

    function automatic logic frame_bit(input logic [FW-1:0] f, input int pos);
        int k;
        int j;
        k = pos / SLOT_BITS;
        j = pos % SLOT_BITS;
        if (j >= W) return 1'b0;
        return f[k * W + W - 1 - j];
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        played_q.delete();
        played_q.push_back('0);
        adc_q.delete();
        hold        = '0;
        hold_full   = 1'b0;
        m_underrun  = 1'b0;
        m_adc_valid = 1'b0;
        m_adc_data  = '0;
        last_obs    = -1;
        first_seen  = 1'b0;
    endtask

    // Drive sdout with the ADC bit for frame position (bit_cnt - 1)
    task automatic drive_sdout();
        int q;
        int p;
        int fr;
        q = n / BICK_DIV;
        if (q == 0) begin
            sdout = 1'b0;
        end else begin
            p  = q - 1;
            fr = p / FRAME;
            while (adc_q.size() <= fr) begin
                if (adc_q.size() < 2)
                    adc_q.push_back({16'h1233, 16'h1232, 16'h1231, 16'h1230});
                else
                    adc_q.push_back({$urandom, $urandom});
            end
            if ((p % FRAME) % SLOT_BITS >= W)
                sdout = 1'($urandom_range(0, 1));
            else
                sdout = frame_bit(adc_q[fr], p % FRAME);
        end
    endtask

    // Advance one clk, update the model, check every output, drive next inputs
    task automatic step();
        bit            xfer;
        int            q;
        int            qs;
        logic          exp_sdin;
        xfer = dac_valid && !hold_full && !rst;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            n++;
            q = n / BICK_DIV;
            if ((n % BICK_DIV == 0) && (q % FRAME == 0) && (q > 0)) begin
                if (hold_full) begin
                    played_q.push_back(hold);
                end else begin
                    played_q.push_back(played_q[played_q.size() - 1]);
                    m_underrun = 1'b1;
                end
                hold_full = 1'b0;
            end
            if (xfer) begin
                hold      = dac_data;
                hold_full = 1'b1;
            end
            m_adc_valid = 1'b0;
            if ((n >= 2) && ((n - 2) % BICK_DIV == H - 1)) begin
                qs = (n - 2) / BICK_DIV;
                if ((qs >= 1) && ((qs - 1) % FRAME == LASTPOS)) begin
                    m_adc_valid = 1'b1;
                    m_adc_data  = adc_q[(qs - 1) / FRAME];
                end
            end
        end
        #1;
        q = n / BICK_DIV;
        exp_sdin = (q == 0) ? 1'b0 : frame_bit(played_q[(q - 1) / FRAME], (q - 1) % FRAME);
        check("mclk",      FW'(mclk),      FW'(1'b1));
        check("bick",      FW'(bick),      FW'((n % BICK_DIV) >= H));
        check("lrck",      FW'(lrck),      FW'((q % FRAME) < SLOT_BITS));
        check("sdin",      FW'(sdin),      FW'(exp_sdin));
        check("dac_ready", FW'(dac_ready), FW'(!hold_full));
        check("adc_valid", FW'(adc_valid), FW'(m_adc_valid));
        check("adc_data",  adc_data,       m_adc_data);
        check("underrun",  FW'(underrun),  FW'(m_underrun));
        if (adc_valid === 1'b1) begin
            if (!first_seen) begin
                check("adc_first_n", FW'(n), FW'(FIRST_N));
                first_seen = 1'b1;
            end
            if (last_obs >= 0) begin
                check("adc_period", FW'(n - last_obs), FW'(PERIOD));
            end
            last_obs = n;
        end
        if (xfer) dac_valid = 1'b0;
        if (feed_en && !dac_valid && !rst && ($urandom_range(0, 3) == 0)) begin
            dac_data  = {$urandom, $urandom};
            dac_valid = 1'b1;
        end
        drive_sdout();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Advance until the next clk edge is a frame load point
    task automatic run_to_load();
        for (int i = 0; i < PERIOD && ((n + 1) % PERIOD) != 0; i++) step();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sdout     = 1'b0;
        dac_valid = 1'b0;
        dac_data  = '0;
        feed_en   = 1'b0;
`ifdef TDM_SERIAL_PORT_LOOPBACK_EN
        loopback  = 1'b0;
`endif
        model_reset();

        // Reset values
        run(3);
        rst = 1'b0;

        // First frame plays zeros; the fixed frame below plays in frame 1,
        // and ADC frames 0/1 carry 0x1230+k in slot k.
        dac_data  = {16'h4000, 16'hC000, 16'h0001, 16'h8000};
        dac_valid = 1'b1;
        step();
        check("t2_accepted", FW'(dac_ready), FW'(1'b0));
        feed_en = 1'b1;
        run(4 * PERIOD);

        // Offer a frame on the load edge while the holding register is full
        run_to_load();
        check("t5_hold_full_before_load", FW'(dac_ready), FW'(1'b0));
        dac_data  = {$urandom, $urandom};
        dac_valid = 1'b1;
        step();
        check("t5_ready_after_load", FW'(dac_ready), FW'(1'b1));
        step();
        check("t5_taken", FW'(dac_ready), FW'(1'b0));
        run(2 * PERIOD);
        check("t5_no_underrun", FW'(underrun), FW'(1'b0));

        // Starve the DAC side: last frame repeats and underrun sticks
        feed_en = 1'b0;
        run(3 * PERIOD);
        check("t4_underrun_sticky", FW'(underrun), FW'(1'b1));

        // Transfer and load on the same edge with the holding register empty
        run_to_load();
        dac_data  = {$urandom, $urandom};
        dac_valid = 1'b1;
        step();
        feed_en = 1'b1;
        run(2 * PERIOD);
        check("underrun_held", FW'(underrun), FW'(1'b1));

        // Reset in the middle of a frame at bit_cnt 70
        for (int i = 0; i < PERIOD && ((n / BICK_DIV) % FRAME) != 70; i++) step();
        rst = 1'b1;
        step();
        check("t6_underrun_cleared", FW'(underrun), FW'(1'b0));
        check("t6_lrck_reset", FW'(lrck), FW'(1'b1));
        rst = 1'b0;
        run(2 * PERIOD + 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
